// File: rtl/level_sequencer_if.sv
// Request/status bundle between a level-request source and level_sequencer.
// Level values are carried as plain 32-bit words holding level_e encodings.
interface level_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_target;
    logic        abort;
    logic [31:0] cur_level;
    logic        busy;
    logic        done;
    logic        err;
    logic        aborted;
    logic [2:0]  step_count;
    logic [31:0] num_levels;

    modport master (
        output req_valid, req_target, abort,
        input  req_ready, cur_level, busy, done, err, aborted, step_count, num_levels
    );

    modport slave (
        input  req_valid, req_target, abort,
        output req_ready, cur_level, busy, done, err, aborted, step_count, num_levels
    );
endinterface

// File: rtl/level_sequencer.sv
// Walks the applied operating level toward a requested target one enum member
// per step, with a programmable dwell between steps.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a request; rejects non-members, completes equal target
// ST_MOVE | stepping toward the latched target, dwell counter between steps

package enum_types;
    typedef enum int {
        E_NONE   = 0,
        E_LOW    = 10,
        E_MEDIUM = 20,
        E_HIGH   = 30,
        E_MAX    = 40
    } level_e;
endpackage

module level_sequencer
    import enum_types::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    level_sequencer_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MOVE = 1'b1;

    // E_NONE <-> E_MAX distance; the step counter saturates here.
    localparam logic [2:0] STEP_MAX = 3'd4;

    logic [0:0] state;
    level_e     cur_level;
    level_e     target;
    level_e     next_level;
    logic [7:0] dwell_cnt;
    logic [2:0] step_count;
    logic       done;
    logic       err;
    logic       aborted;

    function automatic logic is_member(input logic [31:0] val);
        case (val)
            32'd0, 32'd10, 32'd20, 32'd30, 32'd40: is_member = 1'b1;
            default:                               is_member = 1'b0;
        endcase
    endfunction

    // Neighbouring member in the direction of the target; no wrap-around.
    always_comb begin
        next_level = cur_level;
        if (target > cur_level) begin
            next_level = cur_level.next();
        end else if (target < cur_level) begin
            next_level = cur_level.prev();
        end
    end

    // Request acceptance, stepping, dwell timing and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_level  <= E_NONE;
            target     <= E_NONE;
            dwell_cnt  <= 8'd0;
            step_count <= 3'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            aborted <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (!is_member(bus.req_target)) begin
                            err <= 1'b1;
                        end else if (bus.req_target == 32'(cur_level)) begin
                            done       <= 1'b1;
                            step_count <= 3'd0;
                        end else begin
                            target     <= level_e'(bus.req_target);
                            step_count <= 3'd0;
                            dwell_cnt  <= 8'd0;
                            state      <= ST_MOVE;
                        end
                    end
                end
                ST_MOVE: begin
                    if (bus.abort) begin
                        state   <= ST_IDLE;
                        aborted <= 1'b1;
                    end else if (dwell_cnt != 8'd0) begin
                        dwell_cnt <= dwell_cnt - 8'd1;
                    end else begin
                        cur_level <= next_level;
                        dwell_cnt <= 8'(DWELL_CYCLES);
                        if (step_count != STEP_MAX) begin
                            step_count <= step_count + 3'd1;
                        end
                        if (next_level == target) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.busy       = (state == ST_MOVE);
    assign bus.cur_level  = 32'(cur_level);
    assign bus.step_count = step_count;
    assign bus.done       = done;
    assign bus.err        = err;
    assign bus.aborted    = aborted;
    assign bus.num_levels = 32'(cur_level.num());

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: every request pushes its expected
// completion (pulse kind, level, step count) and pulses are popped and compared.
module tb_level_sequencer;

    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;
    localparam int K_ABORT = 4;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] level;
        logic [31:0] steps;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    level_sequencer_if bus ();

    level_sequencer #(.DWELL_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; pulses seen after the edge are matched against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.done || bus.err || bus.aborted) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_pulse: observed done=%0b err=%0b aborted=%0b expected none",
                       bus.done, bus.err, bus.aborted);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.tag, "_kind"}, {29'd0, bus.aborted, bus.err, bus.done}, 32'(e.kind));
                chk({e.tag, "_level"}, bus.cur_level, e.level);
                chk({e.tag, "_steps"}, {29'd0, bus.step_count}, e.steps);
            end
        end
    endtask

    task automatic send(input string tag, input logic [31:0] tgt, input int kind,
                        input logic [31:0] lvl, input logic [31:0] steps);
        exp_t e;
        e.tag   = tag;
        e.kind  = kind;
        e.level = lvl;
        e.steps = steps;
        sb.push_back(e);
        bus.req_valid  = 1'b1;
        bus.req_target = tgt;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int waited;
        waited = 0;
        while (!bus.req_ready && waited < budget) begin
            tick();
            waited++;
        end
        chk({tag, "_timeout"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cur"}, bus.cur_level, 32'd0);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_pulses"}, {29'd0, bus.aborted, bus.err, bus.done}, 32'd0);
        chk({tag, "_steps"}, {29'd0, bus.step_count}, 32'd0);
        chk({tag, "_num"}, bus.num_levels, 32'd5);
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_target = 32'd0;
        bus.abort      = 1'b0;

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk_reset_vals("rst_idle");

        // Move up E_NONE -> E_MAX: level at Ek is 10*((k-1)/5 + 1).
        send("up", 32'd40, K_DONE, 32'd40, 32'd4);
        chk("up_busy", {31'd0, bus.busy}, 32'd1);
        chk("up_ready", {31'd0, bus.req_ready}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("up_cur_e%0d", k), bus.cur_level, 32'(10 * ((k - 1) / 5 + 1)));
        end
        chk("up_ready_with_done", {31'd0, bus.req_ready}, 32'd1);
        chk("up_sb_empty", 32'(sb.size()), 32'd0);

        // Move down: to E_HIGH, then E_HIGH -> E_LOW in two steps.
        send("to_high", 32'd30, K_DONE, 32'd30, 32'd1);
        wait_idle("to_high", 20);
        send("down", 32'd10, K_DONE, 32'd10, 32'd2);
        tick();
        chk("down_first_step", bus.cur_level, 32'd20);
        wait_idle("down", 20);
        chk("down_cur", bus.cur_level, 32'd10);

        // Rejected target leaves level and step count alone.
        send("invalid", 32'd15, K_ERR, 32'd10, 32'd2);
        chk("invalid_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("invalid_cur", bus.cur_level, 32'd10);

        // Equal target completes in one cycle with zero steps.
        send("equal", 32'd10, K_DONE, 32'd10, 32'd0);
        chk("equal_busy", {31'd0, bus.busy}, 32'd0);

        // Abort at E3 of a move from E_NONE.
        send("to_none", 32'd0, K_DONE, 32'd0, 32'd1);
        wait_idle("to_none", 20);
        send("abort", 32'd40, K_ABORT, 32'd10, 32'd1);
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (8) tick();
        chk("abort_hold", bus.cur_level, 32'd10);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);
        send("after_abort", 32'd20, K_DONE, 32'd20, 32'd1);
        wait_idle("after_abort", 20);
        chk("after_abort_cur", bus.cur_level, 32'd20);

        // Abort while idle does nothing.
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("idle_abort_cur", bus.cur_level, 32'd20);
        chk("idle_abort_ready", {31'd0, bus.req_ready}, 32'd1);

        // req_valid with target 0 held during a move is ignored.
        send("busy_ign", 32'd40, K_DONE, 32'd40, 32'd2);
        bus.req_valid  = 1'b1;
        bus.req_target = 32'd0;
        tick();
        chk("busy_ign_e1", bus.cur_level, 32'd30);
        chk("busy_ign_busy", {31'd0, bus.busy}, 32'd1);
        repeat (4) tick();
        bus.req_valid = 1'b0;
        tick();
        chk("busy_ign_e6", bus.cur_level, 32'd40);
        chk("busy_ign_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-move discards the move without any pulse.
        send("rst_move", 32'd0, K_DONE, 32'd0, 32'd4);
        tick();
        tick();
        chk("rst_move_cur", bus.cur_level, 32'd30);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk_reset_vals("rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
